phase_timer: RTL

Parametrised successor to the train controller's per-state time selector. It holds a programmable duration for every controller state code and loads the matching duration when the state changes. It counts that duration down on a prescaled tick and pulses `expired` when it runs out, so the controller FSM no longer needs an external counter. It sits between the main train FSM (`present_state` source) and the FSM's timeout input.

---
 rtl/phase_timer_pkg.sv | 15 +
 rtl/phase_timer_duration_table.sv | 34 +++
 rtl/phase_timer.sv | 68 ++++++
 3 files changed

// File: rtl/phase_timer_pkg.sv
// Shared constants and types for the phase timer: default widths,
// train controller state codes and the duration type.
package phase_timer_pkg;

    localparam int TW_DEFAULT = 19;
    localparam int SW_DEFAULT = 4;

    localparam logic [SW_DEFAULT-1:0] ST_DEPART   = 4'b0010;
    localparam logic [SW_DEFAULT-1:0] ST_RUN      = 4'b0011;
    localparam logic [SW_DEFAULT-1:0] ST_APPROACH = 4'b0100;
    localparam logic [SW_DEFAULT-1:0] ST_STOP     = 4'b0101;

    typedef logic [TW_DEFAULT-1:0] duration_t;

endpackage

// File: rtl/phase_timer_duration_table.sv
// Per-state duration register file: one synchronous write port and one
// asynchronous read port, so a same-edge write is seen by the reader only later.
module duration_table
    import phase_timer_pkg::*;
#(
    parameter int TW = TW_DEFAULT,
    parameter int SW = SW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [SW-1:0] waddr,
    input  logic [TW-1:0] wdata,
    input  logic [SW-1:0] raddr,
    output logic [TW-1:0] rdata
);

    logic [TW-1:0] mem [2**SW];

    // NOTE: the table is a register file, not a RAM macro, so every entry is
    // cleared on reset and an unprogrammed state reads back as untimed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**SW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/phase_timer.sv
// Per-state countdown timer: loads the programmed duration on every state
// change and pulses expired for one cycle when the count runs out.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int TW = TW_DEFAULT,
    parameter int SW = SW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_en,
    input  logic          pause,
    input  logic [SW-1:0] present_state,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_addr,
    input  logic [TW-1:0] cfg_data,
    output logic [TW-1:0] tout,
    output logic [TW-1:0] count,
    output logic          running,
    output logic          expired
);

    logic [SW-1:0] prev_state;
    logic [TW-1:0] table_rd;
    logic          state_change;
    logic          dec_en;

    duration_table #(.TW(TW), .SW(SW)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (present_state),
        .rdata (table_rd)
    );

    assign state_change = (present_state != prev_state);
    assign dec_en       = running && tick_en && !pause && (count != '0);

    // NOTE: all state updates use <= so every branch samples the pre-edge
    // values of count and running, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= '0;
            tout       <= '0;
            count      <= '0;
            running    <= 1'b0;
            expired    <= 1'b0;
        end else begin
            prev_state <= present_state;
            expired    <= 1'b0;
            // A state change outranks a final decrement on the same edge.
            if (state_change) begin
                tout    <= table_rd;
                count   <= table_rd;
                running <= (table_rd != '0);
            end else if (dec_en) begin
                count <= count - TW'(1);
                if (count == TW'(1)) begin
                    running <= 1'b0;
                    expired <= 1'b1;
                end
            end
        end
    end

endmodule
